// File: rtl/channel_frame_sequencer.sv
// channel_frame_sequencer
//
// Sweeps a multiplexed two-input ADC front end round-robin over CHANELS
// channels. After each channel switch it drops SETTLE samples. It then
// forwards FRAME_LENGTH sample pairs to computing_cascade. It holds the
// channel tag until the cascade reports ac_ph_finish, or until TIMEOUT
// cycles pass, and then moves to the next channel.
//
// Optional build macro: CHANNEL_MASK_EN adds chan_mask. The sweep then
// visits only the channels whose mask bit is set.
//
// Ports:
//   clk                  clock
//   rstn                 asynchronous active-low reset
//   en                   run enable, sampled in IDLE and at frame boundaries
//   s_vld, s_x1, s_x2    front-end sample strobe and sample pair
//   ac_ph_finish         frame-finish pulse from the cascade
//   chan_mask            channel enable mask (CHANNEL_MASK_EN only)
//   ch_sel               analog mux select
//   address_registration channel tag for the cascade (same register as ch_sel)
//   i_vld, x1, x2        registered sample strobe and pair to the cascade
//   busy                 high in every state except IDLE
//   sweep_done           one-cycle pulse when the sweep wraps after a finish
//   timeout              sticky WAIT_FIN timeout flag, cleared only by reset
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | stopped, waiting for en
// SETTLE     | dropping settling samples after a channel switch
// FRAME      | forwarding FRAME_LENGTH sample pairs to the cascade
// WAIT_FIN   | frame sent, holding the tag until ac_ph_finish or timeout

module channel_frame_sequencer #(
    parameter int CHANELS      = 4,
    parameter int FRAME_LENGTH = 360,
    parameter int X_WIDTH      = 16,
    parameter int SETTLE       = 8,
    parameter int TIMEOUT      = 4096,
    localparam int AW          = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               s_vld,
    input  logic [X_WIDTH-1:0] s_x1,
    input  logic [X_WIDTH-1:0] s_x2,
    input  logic               ac_ph_finish,
`ifdef CHANNEL_MASK_EN
    input  logic [CHANELS-1:0] chan_mask,
`endif
    output logic [AW-1:0]      ch_sel,
    output logic [AW-1:0]      address_registration,
    output logic               i_vld,
    output logic [X_WIDTH-1:0] x1,
    output logic [X_WIDTH-1:0] x2,
    output logic               busy,
    output logic               sweep_done,
    output logic               timeout
);

    localparam int SMAX = (SETTLE > FRAME_LENGTH) ? SETTLE : FRAME_LENGTH;
    localparam int CW   = $clog2(SMAX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SETTLE   = 2'd1;
    localparam logic [1:0] S_FRAME    = 2'd2;
    localparam logic [1:0] S_WAIT_FIN = 2'd3;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_LENGTH - 1);
    localparam logic [TW-1:0] TO_LOAD     = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] CH_LAST     = AW'(CHANELS - 1);

    logic [1:0]    state;
    logic [AW-1:0] ch;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;

    logic [AW-1:0] ch_next;
    logic [AW-1:0] ch_first;
    logic          adv_wrap;
    logic          mask_any;

`ifdef CHANNEL_MASK_EN
    // The next channel is the first set mask bit after the current one,
    // searched cyclically. If the search lands at or below the current
    // channel, the sweep has wrapped past the highest enabled channel.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        ch_next  = ch;
        ch_first = '0;
        mask_any = |chan_mask;
        for (int i = 1; i <= CHANELS; i++) begin
            idx = (int'(ch) + i) % CHANELS;
            if (!found && chan_mask[idx[AW-1:0]]) begin
                ch_next = AW'(idx);
                found   = 1'b1;
            end
        end
        for (int i = CHANELS - 1; i >= 0; i--) begin
            if (chan_mask[i[AW-1:0]]) begin
                ch_first = AW'(i);
            end
        end
        adv_wrap = found && (ch_next <= ch);
    end
`else
    always_comb begin
        ch_next  = (ch == CH_LAST) ? '0 : ch + AW'(1);
        adv_wrap = (ch == CH_LAST);
        ch_first = ch;
        mask_any = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            ch         <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            i_vld      <= 1'b0;
            x1         <= '0;
            x2         <= '0;
            sweep_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            i_vld      <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && mask_any) begin
                        state <= S_SETTLE;
                        cnt   <= '0;
                        ch    <= ch_first;
                    end
                end
                S_SETTLE: begin
                    if (s_vld) begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= S_FRAME;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_FRAME: begin
                    if (s_vld) begin
                        i_vld <= 1'b1;
                        x1    <= s_x1;
                        x2    <= s_x2;
                        if (cnt == FRAME_LAST) begin
                            cnt   <= '0;
                            tcnt  <= TO_LOAD;
                            state <= S_WAIT_FIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_WAIT_FIN: begin
                    // A timeout advances exactly like a finish but never
                    // reports a completed sweep.
                    if (ac_ph_finish || tcnt == '0) begin
                        if (ac_ph_finish) begin
                            sweep_done <= adv_wrap && mask_any;
                        end else begin
                            timeout <= 1'b1;
                        end
                        cnt <= '0;
                        if (mask_any) begin
                            ch    <= ch_next;
                            state <= en ? S_SETTLE : S_IDLE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ch_sel               = ch;
    assign address_registration = ch;
    assign busy                 = (state != S_IDLE);

endmodule
